// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types and constants for the cache refill arbiter slice.
package cache_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/cache_refill_arbiter_if.sv
// Refill request, completion and main-memory signals shared by the arbiter and its clients.
interface cache_refill_arbiter_if #(
  parameter int ADDR_WIDTH       = 64,
  parameter int CACHE_LINE_WIDTH = 256
);

  logic                        i_ic_req;
  logic [ADDR_WIDTH-1:0]       i_ic_addr;
  logic                        o_ic_done;
  logic [CACHE_LINE_WIDTH-1:0] o_ic_line;
  logic                        i_dc_req;
  logic [ADDR_WIDTH-1:0]       i_dc_addr;
  logic                        o_dc_done;
  logic [CACHE_LINE_WIDTH-1:0] o_dc_line;
  logic                        o_mem_read_req;
  logic [ADDR_WIDTH-1:0]       o_mem_read_address;
  logic                        i_mem_read_done;
  logic [CACHE_LINE_WIDTH-1:0] i_cache_line;
  logic                        o_err;
  logic                        o_err_src;

  modport slave (
    input  i_ic_req, i_ic_addr, i_dc_req, i_dc_addr, i_mem_read_done, i_cache_line,
    output o_ic_done, o_ic_line, o_dc_done, o_dc_line, o_mem_read_req,
           o_mem_read_address, o_err, o_err_src
  );

  modport master (
    output i_ic_req, i_ic_addr, i_dc_req, i_dc_addr, i_mem_read_done, i_cache_line,
    input  o_ic_done, o_ic_line, o_dc_done, o_dc_line, o_mem_read_req,
           o_mem_read_address, o_err, o_err_src
  );

endinterface

// File: rtl/cache_refill_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant plus a last-grant register.
module rr_arbiter2
  import cache_refill_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic       o_gnt_vld,
  output req_id_t    o_gnt_id
);

  req_id_t last_r;

  // Grant: a lone requester always wins, a tie goes to the one not granted last.
  always_comb begin
    o_gnt_vld = i_en & (i_req != 2'b00);
    if (i_req == 2'b11) begin
      o_gnt_id = (last_r == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (i_req[1]) begin
      o_gnt_id = REQ_DC;
    end else begin
      o_gnt_id = REQ_IC;
    end
  end

  // Last-grant history; starts at D-cache so the I-cache takes the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_r <= REQ_DC;
    end else if (o_gnt_vld) begin
      last_r <= o_gnt_id;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Serialises I-cache and D-cache line refills onto one main-memory read port,
// one refill in flight, with a bounded wait for the memory response.
module cache_refill_arbiter
  import cache_refill_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH       = 64,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  cache_refill_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

  localparam logic [1:0] ST_IDLE  = 2'(ARB_IDLE);
  localparam logic [1:0] ST_ISSUE = 2'(ARB_ISSUE);
  localparam logic [1:0] ST_WAIT  = 2'(ARB_WAIT);
  localparam logic [1:0] ST_RESP  = 2'(ARB_RESP);

  logic [1:0]                  state_r;
  req_id_t                     win_r;
  logic [ADDR_WIDTH-1:0]       addr_r;
  logic [CNT_W-1:0]            cnt_r;
  logic [CACHE_LINE_WIDTH-1:0] ic_line_r;
  logic [CACHE_LINE_WIDTH-1:0] dc_line_r;
  logic                        ic_done_r;
  logic                        dc_done_r;
  logic                        mem_req_r;
  logic                        err_r;
  logic                        err_src_r;
  logic                        skip_vld_r;
  req_id_t                     skip_id_r;

  logic [1:0]            req_vec_s;
  logic                  arb_en_s;
  logic                  gnt_vld_s;
  req_id_t               gnt_id_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;

  // The requester just served still holds req for one IDLE cycle; hide it then.
  assign req_vec_s[0] = bus.i_ic_req & ~(skip_vld_r & (skip_id_r == REQ_IC));
  assign req_vec_s[1] = bus.i_dc_req & ~(skip_vld_r & (skip_id_r == REQ_DC));
  assign arb_en_s     = (state_r == ST_IDLE);
  assign sel_addr_s   = (gnt_id_s == REQ_DC) ? bus.i_dc_addr : bus.i_ic_addr;

  rr_arbiter2 u_rr_arbiter2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (arb_en_s),
    .i_req     (req_vec_s),
    .o_gnt_vld (gnt_vld_s),
    .o_gnt_id  (gnt_id_s)
  );

  // Refill FSM; every output is a register set on the transition into its state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      win_r      <= REQ_IC;
      addr_r     <= '0;
      cnt_r      <= '0;
      ic_line_r  <= '0;
      dc_line_r  <= '0;
      ic_done_r  <= 1'b0;
      dc_done_r  <= 1'b0;
      mem_req_r  <= 1'b0;
      err_r      <= 1'b0;
      err_src_r  <= 1'b0;
      skip_vld_r <= 1'b0;
      skip_id_r  <= REQ_IC;
    end else begin
      mem_req_r  <= 1'b0;
      ic_done_r  <= 1'b0;
      dc_done_r  <= 1'b0;
      err_r      <= 1'b0;
      skip_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_vld_s) begin
            win_r     <= gnt_id_s;
            addr_r    <= sel_addr_s & ALIGN_MASK;
            mem_req_r <= 1'b1;
            state_r   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_r   <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.i_mem_read_done) begin
            if (win_r == REQ_DC) begin
              dc_line_r <= bus.i_cache_line;
              dc_done_r <= 1'b1;
            end else begin
              ic_line_r <= bus.i_cache_line;
              ic_done_r <= 1'b1;
            end
            state_r <= ST_RESP;
          end else if (cnt_r == CNT_LAST) begin
            // This cycle brings the count to TIMEOUT_CYCLES: give up without a done.
            cnt_r     <= cnt_r + CNT_ONE;
            err_r     <= 1'b1;
            err_src_r <= win_r;
            state_r   <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RESP: begin
          skip_vld_r <= 1'b1;
          skip_id_r  <= win_r;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ic_done          = ic_done_r;
  assign bus.o_ic_line          = ic_line_r;
  assign bus.o_dc_done          = dc_done_r;
  assign bus.o_dc_line          = dc_line_r;
  assign bus.o_mem_read_req     = mem_req_r;
  assign bus.o_mem_read_address = addr_r;
  assign bus.o_err              = err_r;
  assign bus.o_err_src          = err_src_r;

endmodule
